// File: rtl/alu_checker.sv
// -----------------------------------------------------------------------------
// alu_checker
//
// Scoreboard for a 16-bit ALU. Each accepted sample (operands, carry-in,
// opcode, and the ALU's own result/flags) is registered in stage 1. On the
// following edge stage 2 computes the expected result and updates the
// pass/fail/skip counters and the sticky error flag. One sample per cycle.
//
// Parameters
//   CNT_W         width of pass/fail counters and the accept index
//   STOP_ON_FAIL  1: the first mismatch moves the checker to HALT
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   clear            synchronous flush of counters, pipeline and state
//   smp_valid/ready  sample handshake (ready low only in HALT)
//   smp_X, smp_Y     ALU operands
//   smp_Cin, smp_opcod  carry-in and opcode
//   smp_out          ALU result under test
//   smp_Cout, smp_lt, smp_eq, smp_gt, smp_V  ALU flags under test
//   pass_cnt, fail_cnt  saturating match / mismatch counts
//   skip_cnt         saturating count of opcodes 0100-1111 (not checked)
//   err              sticky mismatch flag
//   halted           checker is in HALT
//   first_fail_idx   accept index of the first mismatch
//
// Build option
//   ALU_CHK_FLAGS_EN  when defined, flags (Cout, V, lt, eq, gt) must match
//                     as well as the result; otherwise only smp_out is compared.
// -----------------------------------------------------------------------------
module alu_checker #(
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             smp_valid,
    output logic             smp_ready,
    input  logic [15:0]      smp_X,
    input  logic [15:0]      smp_Y,
    input  logic             smp_Cin,
    input  logic [3:0]       smp_opcod,
    input  logic [15:0]      smp_out,
    input  logic             smp_Cout,
    input  logic             smp_lt,
    input  logic             smp_eq,
    input  logic             smp_gt,
    input  logic             smp_V,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [7:0]       skip_cnt,
    output logic             err,
    output logic             halted,
    output logic [CNT_W-1:0] first_fail_idx
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t           state;
    logic [CNT_W-1:0] acc_idx;
    logic             accept;

    logic             s1_valid;
    logic [CNT_W-1:0] s1_idx;
    logic [15:0]      s1_x, s1_y, s1_out;
    logic             s1_cin, s1_cout, s1_lt, s1_eq, s1_gt, s1_v;
    logic [3:0]       s1_op;

    logic [16:0]      sum17;
    logic [15:0]      y_eff;
    logic [15:0]      exp_out;
    logic             exp_cout, exp_lt, exp_eq, exp_gt, exp_v;
    logic             checked;
    logic             match;

    assign smp_ready = (state != HALT);
    assign halted    = (state == HALT);
    // clear wins over a simultaneous handshake: that sample is dropped
    assign accept    = smp_valid && smp_ready && !clear;

    // Stage 1 payload: captured on accept, no reset needed since s1_valid gates it
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_idx  <= acc_idx;
            s1_x    <= smp_X;
            s1_y    <= smp_Y;
            s1_cin  <= smp_Cin;
            s1_op   <= smp_opcod;
            s1_out  <= smp_out;
            s1_cout <= smp_Cout;
            s1_lt   <= smp_lt;
            s1_eq   <= smp_eq;
            s1_gt   <= smp_gt;
            s1_v    <= smp_V;
        end
    end

    // Expected ALU behaviour for the sample held in stage 1.
    // Opcode 0001 subtracts as X + ~Y + 1, so carry and overflow fall out of
    // the same 17-bit adder used for addition.
    always_comb begin
        y_eff    = (s1_op == 4'd1 && s1_cin) ? ~s1_y : s1_y;
        sum17    = {1'b0, s1_x} + {1'b0, y_eff} + {16'b0, s1_cin};
        exp_out  = 16'h0000;
        exp_cout = 1'b0;
        exp_v    = 1'b0;
        exp_lt   = (s1_x < s1_y);
        exp_eq   = (s1_x == s1_y);
        exp_gt   = (s1_x > s1_y);
        checked  = 1'b1;
        case (s1_op)
            4'd0: begin
                exp_out  = sum17[15:0];
                exp_cout = sum17[16];
            end
            4'd1: begin
                exp_out  = sum17[15:0];
                exp_cout = sum17[16];
                exp_v    = (s1_x[15] == y_eff[15]) && (sum17[15] != s1_x[15]);
                exp_lt   = ($signed(s1_x) <  $signed(s1_y));
                exp_gt   = ($signed(s1_x) >  $signed(s1_y));
            end
            4'd2:    exp_out = s1_x & s1_y;
            4'd3:    exp_out = s1_x | s1_y;
            default: checked = 1'b0;
        endcase
    end

`ifdef ALU_CHK_FLAGS_EN
    assign match = (s1_out == exp_out) && (s1_cout == exp_cout) && (s1_v == exp_v) &&
                   (s1_lt == exp_lt) && (s1_eq == exp_eq) && (s1_gt == exp_gt);
`else
    logic flags_unused;
    assign flags_unused = ^{s1_cout, s1_lt, s1_eq, s1_gt, s1_v,
                            exp_cout, exp_lt, exp_eq, exp_gt, exp_v};
    assign match = (s1_out == exp_out);
`endif

    // Control FSM, accept index and stage-2 scoring. A sample already in
    // stage 1 is scored even once HALT is reached; HALT only blocks accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            acc_idx        <= '0;
            s1_valid       <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            skip_cnt       <= '0;
            err            <= 1'b0;
            first_fail_idx <= '0;
        end else if (clear) begin
            state          <= IDLE;
            acc_idx        <= '0;
            s1_valid       <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            skip_cnt       <= '0;
            err            <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                if (state == IDLE) begin
                    state <= RUN;
                end
                // the last representable index is accepted, then we stop
                if (acc_idx == '1) begin
                    state <= HALT;
                end else begin
                    acc_idx <= acc_idx + 1'b1;
                end
            end
            if (s1_valid) begin
                if (!checked) begin
                    if (skip_cnt != '1) skip_cnt <= skip_cnt + 1'b1;
                end else if (match) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                    err <= 1'b1;
                    if (!err) begin
                        first_fail_idx <= s1_idx;
                    end
                    if (STOP_ON_FAIL) begin
                        state <= HALT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_checker.sv
// -----------------------------------------------------------------------------
// tb_alu_checker
//
// Two checkers share one stimulus stream: instance A (CNT_W=16, free running)
// and instance B (CNT_W=8, STOP_ON_FAIL=1) so that halting and counter/index
// saturation are reachable in a short run. A behavioural model predicts every
// output of both instances; a compare process checks them on each falling edge.
// Directed sequences add literal expectations on top of the model.
// -----------------------------------------------------------------------------
module tb_alu_checker;

    typedef struct {
        logic [15:0] x, y, out;
        logic        cin;
        logic [3:0]  op;
        logic        cout, lt, eq, gt, v;
    } sample_t;

    logic        clk = 1'b0;
    logic        rst_n, clear, smp_valid;
    logic [15:0] smp_X, smp_Y, smp_out;
    logic        smp_Cin, smp_Cout, smp_lt, smp_eq, smp_gt, smp_V;
    logic [3:0]  smp_opcod;

    logic        a_ready, a_err, a_halted;
    logic [15:0] a_pass, a_fail, a_first;
    logic [7:0]  a_skip;
    logic        b_ready, b_err, b_halted;
    logic [7:0]  b_pass, b_fail, b_first;
    logic [7:0]  b_skip;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    // model state, index 0 = instance A, 1 = instance B
    int      passM[2], failM[2], skipM[2], firstM[2], idxM[2], pendIdx[2], cntMax[2];
    bit      errM[2], haltM[2], pendV[2], stopM[2];
    sample_t pendS[2];
    sample_t blank;

    alu_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .smp_valid(smp_valid), .smp_ready(a_ready),
        .smp_X(smp_X), .smp_Y(smp_Y), .smp_Cin(smp_Cin), .smp_opcod(smp_opcod),
        .smp_out(smp_out), .smp_Cout(smp_Cout), .smp_lt(smp_lt), .smp_eq(smp_eq),
        .smp_gt(smp_gt), .smp_V(smp_V), .pass_cnt(a_pass), .fail_cnt(a_fail),
        .skip_cnt(a_skip), .err(a_err), .halted(a_halted), .first_fail_idx(a_first)
    );

    alu_checker #(.CNT_W(8), .STOP_ON_FAIL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .smp_valid(smp_valid), .smp_ready(b_ready),
        .smp_X(smp_X), .smp_Y(smp_Y), .smp_Cin(smp_Cin), .smp_opcod(smp_opcod),
        .smp_out(smp_out), .smp_Cout(smp_Cout), .smp_lt(smp_lt), .smp_eq(smp_eq),
        .smp_gt(smp_gt), .smp_V(smp_V), .pass_cnt(b_pass), .fail_cnt(b_fail),
        .skip_cnt(b_skip), .err(b_err), .halted(b_halted), .first_fail_idx(b_first)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // What a correct ALU produces, from plain integer arithmetic
    function automatic sample_t refSample(input logic [15:0] x, input logic [15:0] y,
                                          input logic cin, input logic [3:0] op);
        sample_t s;
        int ux, uy, sx, sy, r;
        s.x = x; s.y = y; s.cin = cin; s.op = op;
        s.out = 16'h0; s.cout = 1'b0; s.v = 1'b0; s.lt = 1'b0; s.eq = 1'b0; s.gt = 1'b0;
        ux = int'(x); uy = int'(y);
        sx = int'($signed(x)); sy = int'($signed(y));
        r = 0;
        case (op)
            4'd0: begin
                r = ux + uy + int'(cin);
                s.out = r[15:0]; s.cout = r[16];
                s.lt = ux < uy; s.eq = ux == uy; s.gt = ux > uy;
            end
            4'd1: begin
                r = cin ? (sx - sy) : (sx + sy);
                s.out  = r[15:0];
                s.v    = (r > 32767) || (r < -32768);
                s.cout = cin ? (ux >= uy) : ((ux + uy) > 65535);
                s.lt = sx < sy; s.eq = sx == sy; s.gt = sx > sy;
            end
            4'd2: begin
                s.out = x & y;
                s.lt = ux < uy; s.eq = ux == uy; s.gt = ux > uy;
            end
            4'd3: begin
                s.out = x | y;
                s.lt = ux < uy; s.eq = ux == uy; s.gt = ux > uy;
            end
            default: ;
        endcase
        return s;
    endfunction

    // 0 = skipped opcode, 1 = match, 2 = mismatch
    function automatic int classify(input sample_t s);
        sample_t e;
        bit ok;
        if (s.op > 4'd3) return 0;
        e  = refSample(s.x, s.y, s.cin, s.op);
        ok = (s.out == e.out);
`ifdef ALU_CHK_FLAGS_EN
        ok = ok && (s.cout == e.cout) && (s.v == e.v) && (s.lt == e.lt) &&
             (s.eq == e.eq) && (s.gt == e.gt);
`endif
        return ok ? 1 : 2;
    endfunction

    task automatic modelResetOne(input int m);
        passM[m] = 0; failM[m] = 0; skipM[m] = 0; firstM[m] = 0; idxM[m] = 0;
        errM[m] = 1'b0; haltM[m] = 1'b0; pendV[m] = 1'b0; pendIdx[m] = 0;
    endtask

    task automatic modelReset();
        modelResetOne(0);
        modelResetOne(1);
    endtask

    // One clock edge of the reference: score what was accepted last edge,
    // then take the new sample if the handshake happened.
    task automatic modelEdge(input int m, input bit acc, input bit clr, input sample_t s);
        int r;
        if (clr) begin
            modelResetOne(m);
            return;
        end
        if (pendV[m]) begin
            r = classify(pendS[m]);
            if (r == 0) begin
                if (skipM[m] < 255) skipM[m]++;
            end else if (r == 1) begin
                if (passM[m] < cntMax[m]) passM[m]++;
            end else begin
                if (failM[m] < cntMax[m]) failM[m]++;
                if (!errM[m]) firstM[m] = pendIdx[m];
                errM[m] = 1'b1;
                if (stopM[m]) haltM[m] = 1'b1;
            end
        end
        pendV[m] = acc;
        if (acc) begin
            pendS[m]   = s;
            pendIdx[m] = idxM[m];
            if (idxM[m] == cntMax[m]) haltM[m] = 1'b1;
            else idxM[m]++;
        end
    endtask

    // Called just after a falling edge; returns on the next falling edge
    task automatic applyStimulus(input sample_t s, input bit valid, input bit clr);
        bit acc[2];
        smp_X = s.x; smp_Y = s.y; smp_Cin = s.cin; smp_opcod = s.op; smp_out = s.out;
        smp_Cout = s.cout; smp_lt = s.lt; smp_eq = s.eq; smp_gt = s.gt; smp_V = s.v;
        smp_valid = valid;
        clear = clr;
        for (int m = 0; m < 2; m++) acc[m] = valid && !clr && !haltM[m];
        @(posedge clk);
        for (int m = 0; m < 2; m++) modelEdge(m, acc[m], clr, s);
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(blank, 1'b0, 1'b0);
    endtask

    task automatic doClear();
        applyStimulus(blank, 1'b0, 1'b1);
    endtask

    function automatic sample_t mk(input logic [15:0] x, input logic [15:0] y, input logic cin,
                                   input logic [3:0] op, input logic [15:0] out, input logic cout,
                                   input logic lt, input logic eq, input logic gt, input logic v);
        sample_t s;
        s.x = x; s.y = y; s.cin = cin; s.op = op; s.out = out;
        s.cout = cout; s.lt = lt; s.eq = eq; s.gt = gt; s.v = v;
        return s;
    endfunction

    // Mostly-correct random sample with occasional corrupted result or flag
    function automatic sample_t randSample();
        sample_t s;
        logic [15:0] x, y;
        logic [3:0]  op;
        int k;
        x  = 16'($urandom);
        y  = ($urandom % 8 == 0) ? x : 16'($urandom);
        op = ($urandom % 4 != 0) ? 4'($urandom % 4) : 4'($urandom % 16);
        s  = refSample(x, y, 1'($urandom), op);
        k  = int'($urandom % 16);
        if (k == 0)      s.out = s.out ^ 16'(1 << ($urandom % 16));
        else if (k == 1) s.cout = ~s.cout;
        else if (k == 2) s.v = ~s.v;
        else if (k == 3) s.eq = ~s.eq;
        return s;
    endfunction

    // Every output of both instances against the model, once per cycle
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("a_pass",   int'(a_pass),   passM[0]);
            checkOutput("a_fail",   int'(a_fail),   failM[0]);
            checkOutput("a_skip",   int'(a_skip),   skipM[0]);
            checkOutput("a_err",    int'(a_err),    int'(errM[0]));
            checkOutput("a_halted", int'(a_halted), int'(haltM[0]));
            checkOutput("a_ready",  int'(a_ready),  int'(!haltM[0]));
            checkOutput("a_first",  int'(a_first),  firstM[0]);
            checkOutput("b_pass",   int'(b_pass),   passM[1]);
            checkOutput("b_fail",   int'(b_fail),   failM[1]);
            checkOutput("b_skip",   int'(b_skip),   skipM[1]);
            checkOutput("b_err",    int'(b_err),    int'(errM[1]));
            checkOutput("b_halted", int'(b_halted), int'(haltM[1]));
            checkOutput("b_ready",  int'(b_ready),  int'(!haltM[1]));
            checkOutput("b_first",  int'(b_first),  firstM[1]);
        end
    end

    initial begin
        sample_t s, g[5];
        blank = mk(16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cntMax[0] = 65535; cntMax[1] = 255;
        stopM[0]  = 1'b0;  stopM[1]  = 1'b1;
        rst_n = 1'b0; clear = 1'b0; smp_valid = 1'b0;
        smp_X = 16'h0; smp_Y = 16'h0; smp_Cin = 1'b0; smp_opcod = 4'h0; smp_out = 16'h0;
        smp_Cout = 1'b0; smp_lt = 1'b0; smp_eq = 1'b0; smp_gt = 1'b0; smp_V = 1'b0;
        modelReset();
        checkEn = 1'b1;

        // reset values
        @(negedge clk);
        checkOutput("rst_pass",  int'(a_pass),   0);
        checkOutput("rst_err",   int'(a_err),    0);
        checkOutput("rst_ready", int'(b_ready),  1);
        checkOutput("rst_halt",  int'(b_halted), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // 1 + 2 + 0 = 3, unsigned lt
        applyStimulus(mk(16'd1, 16'd2, 1'b0, 4'd0, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
        idle();
        checkOutput("add_pass",  int'(a_pass), 1);
        checkOutput("add_err",   int'(a_err),  0);
        checkOutput("add_model", passM[0],     1);

        // 300 - 200 = 100 with carry, then the same with a wrong result
        doClear();
        s = mk(16'd300, 16'd200, 1'b1, 4'd1, 16'd100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(s, 1'b1, 1'b0);
        s.out = 16'd500;
        applyStimulus(s, 1'b1, 1'b0);
        idle();
        idle();
        checkOutput("sub_pass",  int'(a_pass),   1);
        checkOutput("sub_fail",  int'(a_fail),   1);
        checkOutput("sub_err",   int'(a_err),    1);
        checkOutput("sub_first", int'(a_first),  1);
        checkOutput("sub_bhalt", int'(b_halted), 1);
        checkOutput("sub_bready", int'(b_ready), 0);

        // AND, OR, then an unchecked opcode
        doClear();
        applyStimulus(mk(16'h5AEE, 16'hF0FC, 1'b0, 4'd2, 16'h50EC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
        applyStimulus(mk(16'h5AEE, 16'hF0FC, 1'b0, 4'd3, 16'hFAFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
        applyStimulus(mk(16'h5AEE, 16'hF0FC, 1'b0, 4'd7, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
        idle();
        idle();
        checkOutput("logic_pass", int'(a_pass), 2);
        checkOutput("logic_skip", int'(a_skip), 1);
        checkOutput("logic_fail", int'(a_fail), 0);

        // stop on fail: index 2 wrong, valid held high through index 4
        doClear();
        for (int i = 0; i < 5; i++) g[i] = refSample(16'($urandom), 16'($urandom), 1'($urandom), 4'(i % 4));
        g[2].out = ~g[2].out;
        for (int i = 0; i < 5; i++) applyStimulus(g[i], 1'b1, 1'b0);
        idle();
        idle();
        checkOutput("stop_bpass",  int'(b_pass),   3);
        checkOutput("stop_bfail",  int'(b_fail),   1);
        checkOutput("stop_bfirst", int'(b_first),  2);
        checkOutput("stop_bhalt",  int'(b_halted), 1);
        checkOutput("stop_bready", int'(b_ready),  0);
        checkOutput("stop_apass",  int'(a_pass),   4);

        // clear wins over a simultaneous accept
        doClear();
        applyStimulus(refSample(16'd5, 16'd9, 1'b0, 4'd0), 1'b1, 1'b1);
        idle();
        idle();
        checkOutput("clr_apass", int'(a_pass),   0);
        checkOutput("clr_bpass", int'(b_pass),   0);
        checkOutput("clr_bhalt", int'(b_halted), 0);

        // flag-only mismatch: overflow reported where there is none
        s = refSample(16'd100, 16'd7, 1'b0, 4'd0);
        s.v = 1'b1;
        applyStimulus(s, 1'b1, 1'b0);
        idle();
`ifdef ALU_CHK_FLAGS_EN
        checkOutput("flag_fail", int'(a_fail), 1);
        checkOutput("flag_pass", int'(a_pass), 0);
`else
        checkOutput("flag_fail", int'(a_fail), 0);
        checkOutput("flag_pass", int'(a_pass), 1);
`endif

        // B: accept index reaches 255 -> HALT, pass count saturates at 255
        doClear();
        for (int i = 0; i < 258; i++)
            applyStimulus(refSample(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom % 4)), 1'b1, 1'b0);
        idle();
        idle();
        checkOutput("sat_bpass", int'(b_pass),   255);
        checkOutput("sat_bhalt", int'(b_halted), 1);
        checkOutput("sat_apass", int'(a_pass),   258);

        // skip counter saturates at 255
        doClear();
        for (int i = 0; i < 300; i++) applyStimulus(refSample(16'd1, 16'd1, 1'b0, 4'd9), 1'b1, 1'b0);
        idle();
        idle();
        checkOutput("sat_askip", int'(a_skip), 255);

        // reset mid-stream drops the in-flight samples
        doClear();
        for (int i = 0; i < 3; i++) applyStimulus(refSample(16'd4, 16'd4, 1'b0, 4'd2), 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        smp_valid = 1'b0;
        clear = 1'b0;
        modelReset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        idle();
        checkOutput("mrst_apass", int'(a_pass), 0);
        checkOutput("mrst_afail", int'(a_fail), 0);

        // randomized stream with occasional clears
        for (int i = 0; i < 4000; i++)
            applyStimulus(randSample(), ($urandom % 4) != 0, ($urandom % 300) == 0);
        idle();
        idle();

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_checker.md
ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of pass/fail/index counters.
REQ-002 SHALL have parameter STOP_ON_FAIL, default 0; when 1, the first mismatch halts sample acceptance.
REQ-003 SHALL have port clk, input, 1, single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clear, input, 1, synchronous flush of counters, pipeline and state.
REQ-006 SHALL have port smp_valid, input, 1, sample present on all smp_* inputs.
REQ-007 SHALL have port smp_ready, output, 1, checker accepts sample this cycle.
REQ-008 SHALL have ports smp_X and smp_Y, input, 16 each, ALU operands.
REQ-009 SHALL have ports smp_Cin, input, 1, and smp_opcod, input, 4, ALU carry-in and opcode.
REQ-010 SHALL have port smp_out, input, 16, DUT result.
REQ-011 SHALL have ports smp_Cout, smp_lt, smp_eq, smp_gt and smp_V, input, 1 each, DUT flags.
REQ-012 SHALL have ports pass_cnt and fail_cnt, output, CNT_W each, saturating counts.
REQ-013 SHALL have port skip_cnt, output, 8, saturating count of unchecked opcodes.
REQ-014 SHALL have ports err, output, 1, sticky mismatch flag, and halted, output, 1, FSM in HALT.
REQ-015 SHALL have port first_fail_idx, output, CNT_W, accept index (0-based) of the first mismatch.

Function
REQ-016 Accept SHALL occur on a rising edge with smp_valid=1 and smp_ready=1; smp_ready=1 in IDLE/RUN, 0 in HALT.
REQ-017 Stage 1 SHALL register all smp_* inputs at accept; stage 2 SHALL update counters/err on the next edge (results visible 2 edges after accept); full throughput, one sample per cycle.
REQ-018 Opcode 0000 SHALL expect {Cout,out}=X+Y+Cin (17-bit unsigned), V=0, lt/eq/gt as unsigned X-vs-Y compare.
REQ-019 Opcode 0001 SHALL expect out=X+Y when Cin=0 and X-Y when Cin=1, Cout = carry out of bit 15 (subtract as X+~Y+1), V = two's-complement overflow, lt/eq/gt as signed compare.
REQ-020 Opcodes 0010 (AND) and 0011 (OR) SHALL expect out=X&Y / X|Y, Cout=0, V=0, lt/eq/gt unsigned.
REQ-021 Opcodes 0100-1111 SHALL increment skip_cnt only, never pass_cnt or fail_cnt.
REQ-022 Match SHALL increment pass_cnt; mismatch SHALL increment fail_cnt and set err; on the first mismatch since reset/clear, first_fail_idx SHALL capture that sample's accept index.
REQ-023 FSM SHALL have states IDLE (after reset/clear) -> RUN (first accept) -> HALT (mismatch with STOP_ON_FAIL=1, or accept index reaching 2^CNT_W-1); HALT exits only via clear or reset.
REQ-024 Samples already in stage 1 when HALT is entered SHALL still be scored.
REQ-025 All counters SHALL saturate at all-ones, never wrap.
REQ-026 clear SHALL take priority over a simultaneous accept; that sample is discarded and the stage-1 contents are dropped.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, smp_ready=1, all counters 0, first_fail_idx 0, err 0, halted 0, stages invalid.
REQ-028 Reset mid-stream SHALL discard in-flight samples with no counter update after release.
REQ-029 clear SHALL produce the same values as reset, on the next edge.

Configuration
REQ-030 With ALU_CHK_FLAGS_EN defined, match SHALL require equal out, Cout, V, lt, eq and gt.
REQ-031 Without ALU_CHK_FLAGS_EN, match SHALL compare out only; flag inputs are ignored.

Verification
REQ-032 X=1,Y=2,Cin=0,op=0000,out=3,Cout=0,lt=1 -> pass_cnt=1 two edges later, err=0.
REQ-033 X=300,Y=200,Cin=1,op=0001,out=100,Cout=1,V=0,gt=1 -> pass; same sample with out=500 -> fail_cnt=1, err=1, first_fail_idx=1.
REQ-034 X=16'h5AEE,Y=16'hF0FC,op=0010,out=16'h50EC, then op=0011,out=16'hFAFE -> pass_cnt=2; op=0111 -> skip_cnt=1.
REQ-035 STOP_ON_FAIL=1: mismatch at index 2 with smp_valid held high -> halted=1, smp_ready=0, the index-3 sample in stage 1 is still scored, no further accepts.
REQ-036 clear and smp_valid high in the same cycle -> all counts 0, state IDLE; flag-only mismatch (e.g. V wrong) fails only with ALU_CHK_FLAGS_EN defined.
